// File: rtl/capture_buffer_pkg.sv
// Shared capture-path definitions: sequencer state encoding and default sample/address widths.
package capture_buffer_pkg;

    localparam int unsigned DATA_W_DEF = 3;
    localparam int unsigned ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_READ    = 3'd4
    } state_t;

endpackage

// File: rtl/capture_ram.sv
// Sample storage: simple dual-port RAM, one write port and one registered read port (1-cycle latency).
module capture_ram
    import capture_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register doubles as the readout data register, so it holds while re is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_buffer.sv
// Pre/post-trigger capture buffer with valid/ready readout.
// Optional feature: define CAPTURE_BUFFER_TRIG_INDEX_EN to report the trigger sample's readout position.
module capture_buffer
    import capture_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_PLL,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              triggerIn,
    input  logic              arm,
    input  logic [ADDR_W-1:0] postCount,
    input  logic              rdReady,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    output logic              rdLast,
    output logic              busy,
    output logic [ADDR_W-1:0] trigIndex
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] p;
    logic [ADDR_W:0]   rd_cnt;

    logic [ADDR_W-1:0] cnt_inc_c;
    logic [ADDR_W-1:0] pre_len_c;
    logic              we_c;
    logic              re_c;
    logic              accept_arm_c;
    logic [ADDR_W-1:0] raddr_c;

    // Pre-trigger length DEPTH-P, taken modulo DEPTH; P is never 0 so this never wraps to 0.
    assign cnt_inc_c = cnt + ADDR_W'(1);
    assign pre_len_c = ~p + ADDR_W'(1);

    always_ff @(posedge clk_PLL) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (arm) state_nxt = S_PREFILL;
            S_PREFILL: if (cnt_inc_c == pre_len_c) state_nxt = S_ARMED;
            S_ARMED:   if (triggerIn) state_nxt = (p == ADDR_W'(1)) ? S_READ : S_POST;
            S_POST:    if (cnt_inc_c == p) state_nxt = S_READ;
            S_READ: begin
                if (arm) begin
                    state_nxt = S_PREFILL;
                end else if (rdValid && rdReady && rdLast) begin
                    state_nxt = S_IDLE;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Fetch the next sample whenever the output slot is empty or is being drained this cycle.
    always_comb begin
        we_c         = 1'b0;
        re_c         = 1'b0;
        accept_arm_c = 1'b0;
        raddr_c      = wr_ptr + rd_cnt[ADDR_W-1:0];
        unique case (state)
            S_PREFILL, S_ARMED, S_POST: we_c = 1'b1;
            S_IDLE:                     accept_arm_c = arm;
            S_READ: begin
                accept_arm_c = arm;
                re_c         = !arm && (!rdValid || rdReady) && !rd_cnt[ADDR_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_PLL) begin
        if (reset) begin
            wr_ptr  <= '0;
            cnt     <= '0;
            p       <= '0;
            rd_cnt  <= '0;
            rdValid <= 1'b0;
            rdLast  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            if (accept_arm_c) begin
                p      <= (postCount == '0) ? ADDR_W'(1) : postCount;
                wr_ptr <= '0;
                cnt    <= '0;
                rd_cnt <= '0;
            end else if (we_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                // Counting restarts at 1 in ARMED so POST sees the trigger sample already stored.
                cnt    <= (state == S_ARMED) ? ADDR_W'(1) : cnt_inc_c;
            end else if (re_c) begin
                rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
            end

            if (accept_arm_c) begin
                rdValid <= 1'b0;
                rdLast  <= 1'b0;
            end else if (re_c) begin
                rdValid <= 1'b1;
                rdLast  <= &rd_cnt[ADDR_W-1:0];
            end else if (rdValid && rdReady) begin
                rdValid <= 1'b0;
                rdLast  <= 1'b0;
            end
        end
    end

`ifdef CAPTURE_BUFFER_TRIG_INDEX_EN
    logic [ADDR_W-1:0] trig_ptr;

    // Trigger position relative to the final write pointer, which is where readout starts.
    always_ff @(posedge clk_PLL) begin
        if (reset) begin
            trig_ptr  <= '0;
            trigIndex <= '0;
        end else begin
            if (state == S_ARMED && triggerIn) begin
                trig_ptr <= wr_ptr;
            end
            if (accept_arm_c) begin
                trigIndex <= '0;
            end else if (state_nxt == S_READ && state != S_READ) begin
                trigIndex <= ((state == S_ARMED) ? wr_ptr : trig_ptr) - (wr_ptr + ADDR_W'(1));
            end
        end
    end
`else
    assign trigIndex = '0;
`endif

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_PLL),
        .rst   (reset),
        .we    (we_c),
        .waddr (wr_ptr),
        .wdata (dataIn),
        .re    (re_c),
        .raddr (raddr_c),
        .q     (rdData)
    );

endmodule

// File: tb/tb_capture_buffer.sv
// Randomized bench for capture_buffer: expected readout is the last DEPTH samples of the captured stream.
module tb_capture_buffer;

    localparam int unsigned DW    = 3;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dataIn;
    logic          triggerIn;
    logic          arm;
    logic [AW-1:0] postCount;
    logic          rdReady;
    logic          rdValid;
    logic [DW-1:0] rdData;
    logic          rdLast;
    logic          busy;
    logic [AW-1:0] trigIndex;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_log[DEPTH];
    int            rx_cnt = 0;
    bit            prev_stall = 0;
    bit            prev_arm   = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_PLL   (clk),
        .reset     (reset),
        .dataIn    (dataIn),
        .triggerIn (triggerIn),
        .arm       (arm),
        .postCount (postCount),
        .rdReady   (rdReady),
        .rdValid   (rdValid),
        .rdData    (rdData),
        .rdLast    (rdLast),
        .busy      (busy),
        .trigIndex (trigIndex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every transfer is scored against the model queue; stalled outputs must hold.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && !prev_arm) begin
                chk("stall_valid", 32'(rdValid), 1);
                chk("stall_data", 32'(rdData), 32'(prev_data));
                chk("stall_last", 32'(rdLast), 32'(prev_last));
            end
            if (rdValid && rdReady) begin
                chk("xfer_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rdData), 32'(e));
                    chk("rd_last", 32'(rdLast), 32'(exp_q.size() == 0));
                end
                if (rx_cnt < DEPTH) rx_log[rx_cnt] = rdData;
                rx_cnt++;
            end
            prev_stall = rdValid && !rdReady;
            prev_data  = rdData;
            prev_last  = rdLast;
            prev_arm   = arm;
        end
    end

    // abort_mode: 0 none, 1 reset in POST, 2 reset in READ after 5, 3 arm in READ after 3.
    task automatic do_capture(input int pc, input int trig_at, input int rmode, input int abort_mode,
                              input bit pre_trigs, input bit data_cnt, input bit noise);
        int p, pre, n, cyc, exp_ti;
        logic [DW-1:0] d[$];
        bit t[$];
        p   = (pc == 0) ? 1 : pc;
        pre = DEPTH - p;
        n   = trig_at + p;
        for (int i = 0; i < n; i++) begin
            d.push_back(data_cnt ? DW'(i) : DW'($urandom));
            if (i == trig_at)      t.push_back(1'b1);
            else if (i < pre)      t.push_back(pre_trigs ? (i >= 1 && i <= 4) : 1'($urandom_range(0, 1)));
            else if (i > trig_at)  t.push_back(1'($urandom_range(0, 1)));
            else                   t.push_back(1'b0);
        end
        exp_q.delete();
        for (int i = n - DEPTH; i < n; i++) exp_q.push_back(d[i]);
`ifdef CAPTURE_BUFFER_TRIG_INDEX_EN
        exp_ti = DEPTH - p;
`else
        exp_ti = 0;
`endif
        rx_cnt    = 0;
        arm       = 1'b1;
        postCount = AW'(pc);
        tick();
        arm       = 1'b0;
        postCount = AW'($urandom);
        chk("busy_after_arm", 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            if (abort_mode == 1 && i == trig_at + 1) begin
                reset = 1'b1;
                triggerIn = 1'b0;
                tick();
                reset = 1'b0;
                exp_q.delete();
                chk("post_rst_busy", 32'(busy), 0);
                chk("post_rst_valid", 32'(rdValid), 0);
                return;
            end
            chk("capture_valid", 32'(rdValid), 0);
            dataIn    = d[i];
            triggerIn = t[i];
            arm       = noise && ($urandom_range(0, 7) == 0);
            postCount = AW'($urandom);
            rdReady   = 1'($urandom_range(0, 1));
            tick();
        end
        arm = 1'b0;
        cyc = 0;
        while (rx_cnt < DEPTH && cyc < 300) begin
            if ((abort_mode == 2 && rx_cnt == 5) || (abort_mode == 3 && rx_cnt == 3)) break;
            triggerIn = 1'($urandom_range(0, 1));
            dataIn    = DW'($urandom);
            case (rmode)
                0:       rdReady = 1'b1;
                1:       rdReady = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdReady = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        if (abort_mode == 2) begin
            rdReady = 1'b0;
            reset   = 1'b1;
            tick();
            reset   = 1'b0;
            exp_q.delete();
            chk("read_rst_valid", 32'(rdValid), 0);
            chk("read_rst_busy", 32'(busy), 0);
            chk("read_rst_last", 32'(rdLast), 0);
            chk("read_rst_data", 32'(rdData), 0);
            chk("read_rst_tidx", 32'(trigIndex), 0);
            return;
        end
        if (abort_mode == 3) begin
            rdReady   = 1'b0;
            arm       = 1'b1;
            postCount = AW'(4);
            tick();
            arm = 1'b0;
            exp_q.delete();
            chk("abort_valid", 32'(rdValid), 0);
            chk("abort_busy", 32'(busy), 1);
            repeat (3) tick();
            chk("abort_prefill_busy", 32'(busy), 1);
            chk("abort_prefill_valid", 32'(rdValid), 0);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("abort_rst_busy", 32'(busy), 0);
            return;
        end
        rdReady = 1'b0;
        chk("xfer_count", 32'(rx_cnt), 32'(DEPTH));
        chk("model_drained", 32'(exp_q.size()), 0);
        chk("idle_valid", 32'(rdValid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("trig_index", 32'(trigIndex), 32'(exp_ti));
        if (rmode == 0) chk("no_bubbles", 32'(cyc <= DEPTH + 2), 1);
        if (rx_cnt != DEPTH) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        int pc, p;
        reset = 1'b1; dataIn = '0; triggerIn = 1'b0; arm = 1'b0; postCount = '0; rdReady = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(rdValid), 0);
        chk("rst_last", 32'(rdLast), 0);
        chk("rst_data", 32'(rdData), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tidx", 32'(trigIndex), 0);
        reset = 1'b0;
        tick();

        // Counter data, trigger on the 20th sample.
        do_capture(4, 19, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("s1_first", 32'(rx_log[0]), 7);
        chk("s1_trig", 32'(rx_log[12]), 3);
        chk("s1_last", 32'(rx_log[15]), 6);

        // Trigger pulses during PREFILL must be ignored.
        do_capture(6, 14, 0, 0, 1'b1, 1'b0, 1'b0);

        // Readout stalls with ready 1,0,0,1.
        do_capture(5, 14, 1, 0, 1'b0, 1'b0, 1'b0);

        // postCount=0 behaves as 1: trigger sample is read last.
        do_capture(0, 17, 2, 0, 1'b0, 1'b1, 1'b0);
        chk("p0_trig_last", 32'(rx_log[15]), 1);

        // Reset mid-POST, then mid-READ, each followed by a clean capture.
        do_capture(5, 12, 0, 1, 1'b0, 1'b0, 1'b0);
        do_capture(7, 11, 0, 0, 1'b0, 1'b0, 1'b0);
        do_capture(3, 15, 0, 2, 1'b0, 1'b0, 1'b0);
        do_capture(2, 16, 2, 0, 1'b0, 1'b0, 1'b1);

        // Arm during READ after 3 transfers.
        do_capture(4, 13, 0, 3, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            pc = $urandom_range(0, DEPTH - 1);
            p  = (pc == 0) ? 1 : pc;
            do_capture(pc, DEPTH - p + int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 0,
                       1'b0, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_buffer.md
CAPTURE_BUFFER -- requirements
Module: capture_buffer

Interface
REQ-001 SHALL provide parameter DATA_W, default 3, giving the sample width; it matches the trigger stage data output.
REQ-002 SHALL provide parameter ADDR_W, default 8, so buffer DEPTH = 2^ADDR_W samples.
REQ-003 SHALL have port clk_PLL, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port dataIn, input, DATA_W bits: the sample stream from the trigger stage dataOut.
REQ-006 SHALL have port triggerIn, input, 1 bit: the trigger stage triggerOut, cycle-aligned with dataIn.
REQ-007 SHALL have port arm, input, 1 bit: a single-cycle start-capture pulse.
REQ-008 SHALL have port postCount, input, ADDR_W bits: the number of samples to store from the trigger sample onward, sampled on arm.
REQ-009 SHALL have port rdReady, input, 1 bit: the readout consumer is ready.
REQ-010 SHALL have port rdValid, output, 1 bit: rdData is valid.
REQ-011 SHALL have port rdData, output, DATA_W bits: the readout sample.
REQ-012 SHALL have port rdLast, output, 1 bit: marks the final readout sample.
REQ-013 SHALL have port busy, output, 1 bit: high in PREFILL, ARMED, POST and READ.
REQ-014 SHALL have port trigIndex, output, ADDR_W bits: the readout position of the trigger sample (see REQ-028).

Function
REQ-015 SHALL implement states IDLE, PREFILL, ARMED, POST and READ.
REQ-016 SHALL move IDLE->PREFILL on arm, latching P = max(postCount,1) and clearing wrPtr and the fill counter.
REQ-017 SHALL, in PREFILL, ARMED and POST, write dataIn to mem[wrPtr] every cycle and increment wrPtr modulo DEPTH.
REQ-018 SHALL stay in PREFILL until DEPTH-P samples are written, then enter ARMED; a triggerIn in PREFILL is ignored.
REQ-019 SHALL, in ARMED, treat the cycle with triggerIn=1 as the trigger sample: write it, latch trigPtr=wrPtr, and enter POST (when P=1, enter READ directly).
REQ-020 SHALL, in POST, write until exactly P samples including the trigger sample are stored, then enter READ with writes stopped.
REQ-021 SHALL, in READ, emit DEPTH samples oldest-first starting at the final wrPtr with address wrap-around, under a valid/ready handshake; a transfer occurs on rdValid&rdReady.
REQ-022 SHALL raise rdValid no later than 2 cycles after READ entry, and hold rdData and rdLast stable while rdValid=1 and rdReady=0.
REQ-023 SHALL sustain one transfer per cycle while rdReady stays high, with no bubbles after the first sample.
REQ-024 SHALL assert rdLast with sample DEPTH-1, then go to IDLE after that transfer, with rdValid low the next cycle.
REQ-025 SHALL ignore arm in PREFILL, ARMED and POST; arm in READ aborts the readout, drops rdValid the next cycle, and starts PREFILL.
REQ-026 SHALL ignore triggerIn outside ARMED, so repeated triggers have no effect.

Reset
REQ-027 SHALL, on reset (synchronous, takes priority over arm), set the state to IDLE, rdValid=0, rdLast=0, rdData=0, busy=0, trigIndex=0 and clear the pointers; memory contents are not cleared; a reset mid-capture or mid-readout discards that capture.

Configuration
REQ-028 SHALL, with macro CAPTURE_BUFFER_TRIG_INDEX_EN defined, drive trigIndex = DEPTH-P from READ entry until the next arm or reset; without the macro, trigIndex is constant 0 and trigPtr logic is omitted.

Structure
REQ-029 SHALL place the state encoding and the default DATA_W and ADDR_W constants in the shared analyzer package.
REQ-030 SHALL hold storage in sub-module capture_ram: simple dual-port, one write port, one registered read port with 1-cycle latency, inferred as FPGA block RAM.

Verification
REQ-031 SHALL pass this scenario: ADDR_W=4, postCount=4, dataIn=counter mod 8, trigger at the 20th sample -> 16 samples read, trigger sample at position 12, rdLast on the 16th.
REQ-032 SHALL pass this scenario: trigger pulses during PREFILL (cycles 2-5 after arm) -> ignored; capture completes only on a later ARMED trigger.
REQ-033 SHALL pass this scenario: rdReady toggled 1,0,0,1 repeatedly -> rdData is stable across stalls, there are no duplicates or drops, and exactly DEPTH transfers occur.
REQ-034 SHALL pass this scenario: postCount=0 -> treated as 1; the trigger sample is the last sample read and trigIndex=DEPTH-1 with the macro, 0 without it.
REQ-035 SHALL pass this scenario: reset asserted mid-POST and mid-READ -> the next cycle shows IDLE, rdValid=0 and busy=0; a following arm captures correctly.
REQ-036 SHALL pass this scenario: arm during READ after 3 transfers -> rdValid falls the next cycle and busy stays high in PREFILL.
